// File: rtl/run_ctrl_trace_if.sv
// Bus bundle for run_ctrl_trace: run/step/breakpoint controls, CPU observation
// buses, execution status and the trace read port.
interface run_ctrl_trace_if #(
  parameter int WIDTH  = 64,
  parameter int INSN_W = 11,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
);
  localparam int TC_W = $clog2(DEPTH) + 1;

  // Control and observation (driven by the debugger / CPU side)
  logic              run;
  logic              step;
  logic              bp_en;
  logic [WIDTH-1:0]  bp_addr;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  alu_result;
  logic [WIDTH-1:0]  mem_out;
  logic [INSN_W-1:0] opcode;
  logic              rd_en;

  // Status and trace read data (driven by the controller)
  logic              cpu_en;
  logic [1:0]        state;
  logic              bp_hit;
  logic [CNT_W-1:0]  cycle_count;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_pc;
  logic [WIDTH-1:0]  rd_alu;
  logic [WIDTH-1:0]  rd_mem;
  logic [INSN_W-1:0] rd_opcode;
  logic [TC_W-1:0]   tr_count;
  logic              tr_empty;
  logic              tr_overflow;

  modport master (
    output run, step, bp_en, bp_addr, pc, alu_result, mem_out, opcode, rd_en,
    input  cpu_en, state, bp_hit, cycle_count, rd_valid, rd_pc, rd_alu, rd_mem,
           rd_opcode, tr_count, tr_empty, tr_overflow
  );

  modport slave (
    input  run, step, bp_en, bp_addr, pc, alu_result, mem_out, opcode, rd_en,
    output cpu_en, state, bp_hit, cycle_count, rd_valid, rd_pc, rd_alu, rd_mem,
           rd_opcode, tr_count, tr_empty, tr_overflow
  );
endinterface

// File: rtl/run_ctrl_trace.sv
// Run/step/breakpoint controller for a CPU clock enable, with an enabled-cycle
// counter and a circular trace buffer of retired instructions that can be
// popped oldest-first. When full, new entries overwrite the oldest one.
module run_ctrl_trace #(
  parameter int WIDTH  = 64,
  parameter int INSN_W = 11,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  run_ctrl_trace_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TC_W  = PTR_W + 1;
  localparam int ENT_W = INSN_W + 3 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_bp_clr;
  logic              w_bp_match;
  logic              w_cpu_en;
  logic              r_bp_hit;
  logic [CNT_W-1:0]  r_cycles;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [ENT_W-1:0]  r_rd_data;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [TC_W-1:0]   r_count;
  logic              r_overflow;
  logic              r_rd_valid;
  logic              w_wr;
  logic              w_rd;
  logic              w_full;

  // Breakpoints only fire during free-running execution; a step ignores them.
  assign w_bp_match = bus.bp_en && (r_state == ST_RUN) && (bus.pc == bus.bp_addr);
  assign w_cpu_en   = (r_state == ST_RUN) || (r_state == ST_STEP);

  // Trace traffic: every enabled cycle writes; a pop needs something to pop.
  assign w_wr   = w_cpu_en;
  assign w_full = (r_count == TC_W'(DEPTH));
  assign w_rd   = bus.rd_en && (r_count != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode; bp_hit is dropped only on the HALT -> IDLE exit
  always_comb begin
    w_state_next = r_state;
    w_bp_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.step)     w_state_next = ST_STEP;
        else if (bus.run) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_bp_match)    w_state_next = ST_HALT;
        else if (!bus.run) w_state_next = ST_IDLE;
      end
      ST_STEP: w_state_next = ST_HALT;
      ST_HALT: begin
        if (bus.step) begin
          w_state_next = ST_STEP;
        end else if (!bus.run) begin
          w_state_next = ST_IDLE;
          w_bp_clr     = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sticky breakpoint flag and saturating enabled-cycle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bp_hit <= 1'b0;
      r_cycles <= '0;
    end else begin
      if (w_bp_match)    r_bp_hit <= 1'b1;
      else if (w_bp_clr) r_bp_hit <= 1'b0;
      if (w_cpu_en && !(&r_cycles)) r_cycles <= r_cycles + CNT_W'(1);
    end
  end

  // Trace storage; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {bus.opcode, bus.pc, bus.alu_result, bus.mem_out};
  end

  // Registered read port; a pop in the same cycle as a write to the same slot
  // returns the old (oldest) entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  // Pointer and occupancy bookkeeping; a write into a full buffer with no pop
  // discards the oldest entry by advancing the read pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd || (w_wr && w_full)) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_rd && w_full) r_overflow <= 1'b1;
      if (w_wr && !w_rd && !w_full) r_count <= r_count + TC_W'(1);
      else if (w_rd && !w_wr)       r_count <= r_count - TC_W'(1);
    end
  end

  assign bus.cpu_en      = w_cpu_en;
  assign bus.state       = r_state;
  assign bus.bp_hit      = r_bp_hit;
  assign bus.cycle_count = r_cycles;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_opcode   = r_rd_data[ENT_W-1 -: INSN_W];
  assign bus.rd_pc       = r_rd_data[3*WIDTH-1 -: WIDTH];
  assign bus.rd_alu      = r_rd_data[2*WIDTH-1 -: WIDTH];
  assign bus.rd_mem      = r_rd_data[WIDTH-1:0];
  assign bus.tr_count    = r_count;
  assign bus.tr_empty    = (r_count == '0);
  assign bus.tr_overflow = r_overflow;
endmodule

// File: tb/tb_run_ctrl_trace.sv
// Bench for run_ctrl_trace: directed scenarios followed by a randomized run,
// every cycle compared against a queue-based reference model.
module tb_run_ctrl_trace;
  localparam int WIDTH  = 64;
  localparam int INSN_W = 11;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 32;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [10:0] op;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [1:0]  m_state;
  logic        m_bp_hit;
  logic [31:0] m_cycles;
  logic        m_ovf;
  logic        m_rd_valid;
  ent_t        m_rd;
  ent_t        m_q[$];
  logic [63:0] pc_mask = 64'hFFFF_FFFF_FFFF_FFFF;

  run_ctrl_trace_if #(.WIDTH(WIDTH), .INSN_W(INSN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  run_ctrl_trace #(.WIDTH(WIDTH), .INSN_W(INSN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 64'(bus.state), 64'(m_state));
    chk("cpu_en", 64'(bus.cpu_en), 64'(m_state == 2'd1 || m_state == 2'd2));
    chk("bp_hit", 64'(bus.bp_hit), 64'(m_bp_hit));
    chk("cycle_count", 64'(bus.cycle_count), 64'(m_cycles));
    chk("tr_count", 64'(bus.tr_count), 64'(m_q.size()));
    chk("tr_empty", 64'(bus.tr_empty), 64'(m_q.size() == 0));
    chk("tr_overflow", 64'(bus.tr_overflow), 64'(m_ovf));
    chk("rd_valid", 64'(bus.rd_valid), 64'(m_rd_valid));
    chk("rd_pc", bus.rd_pc, m_rd.pc);
    chk("rd_alu", bus.rd_alu, m_rd.alu);
    chk("rd_mem", bus.rd_mem, m_rd.mem);
    chk("rd_opcode", 64'(bus.rd_opcode), 64'(m_rd.op));
  endtask

  // One clock: sample inputs, advance the model, check, then let the CPU
  // advance its pc if it retired an instruction and present new data.
  task automatic tick();
    logic s_rst_n, s_run, s_step, s_bp_en, s_rd_en;
    logic [63:0] s_bp, s_pc, s_alu, s_mem;
    logic [10:0] s_op;
    bit   en, bpm, pop;
    ent_t e;
    s_rst_n = rst_n; s_run = bus.run; s_step = bus.step; s_bp_en = bus.bp_en;
    s_rd_en = bus.rd_en; s_bp = bus.bp_addr; s_pc = bus.pc;
    s_alu = bus.alu_result; s_mem = bus.mem_out; s_op = bus.opcode;
    en = 0;
    @(posedge clk);
    if (!s_rst_n) begin
      m_state = 0; m_bp_hit = 0; m_cycles = 0; m_ovf = 0; m_rd_valid = 0;
      m_rd = '{pc: 0, alu: 0, mem: 0, op: 0};
      m_q.delete();
    end else begin
      en  = (m_state == 2'd1) || (m_state == 2'd2);
      bpm = s_bp_en && (m_state == 2'd1) && (s_pc == s_bp);
      if (bpm) m_bp_hit = 1;
      else if (m_state == 2'd3 && !s_step && !s_run) m_bp_hit = 0;
      case (m_state)
        2'd0: if (s_step) m_state = 2'd2; else if (s_run) m_state = 2'd1;
        2'd1: if (bpm) m_state = 2'd3; else if (!s_run) m_state = 2'd0;
        2'd2: m_state = 2'd3;
        default: if (s_step) m_state = 2'd2; else if (!s_run) m_state = 2'd0;
      endcase
      if (en && m_cycles != 32'hFFFF_FFFF) m_cycles++;
      pop = s_rd_en && (m_q.size() > 0);
      m_rd_valid = pop;
      if (pop) m_rd = m_q.pop_front();
      if (en) begin
        if (m_q.size() == DEPTH) begin
          e = m_q.pop_front();
          m_ovf = 1;
        end
        e.pc = s_pc; e.alu = s_alu; e.mem = s_mem; e.op = s_op;
        m_q.push_back(e);
      end
    end
    #1;
    check_all();
    if (en) bus.pc = (bus.pc + 64'd4) & pc_mask;
    bus.alu_result = {$urandom, $urandom};
    bus.mem_out    = {$urandom, $urandom};
    bus.opcode     = 11'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.pc = '0;
  endtask

  initial begin
    bus.run = 0; bus.step = 0; bus.bp_en = 0; bus.bp_addr = '0; bus.pc = '0;
    bus.alu_result = '0; bus.mem_out = '0; bus.opcode = '0; bus.rd_en = 0;
    m_state = 0; m_bp_hit = 0; m_cycles = 0; m_ovf = 0; m_rd_valid = 0;
    m_rd = '{pc: 0, alu: 0, mem: 0, op: 0};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_tr_empty", 64'(bus.tr_empty), 64'd1);
    chk("rst_cycle_count", 64'(bus.cycle_count), 64'd0);

    // Free run for five cycles
    bus.run = 1;
    repeat (5) tick();
    bus.run = 0;
    tick();
    chk("run5_cycles", 64'(bus.cycle_count), 64'd5);
    chk("run5_tr_count", 64'(bus.tr_count), 64'd5);
    chk("run5_state", 64'(bus.state), 64'd0);

    // Breakpoint at 0x10, then a single step
    do_reset();
    bus.bp_en = 1; bus.bp_addr = 64'h10; bus.run = 1;
    repeat (7) tick();
    chk("bp_state_halt", 64'(bus.state), 64'd3);
    chk("bp_hit_set", 64'(bus.bp_hit), 64'd1);
    chk("bp_cycles", 64'(bus.cycle_count), 64'd5);
    chk("bp_last_traced", 64'(bus.tr_count), 64'd5);
    bus.step = 1;
    tick();
    bus.step = 0;
    chk("step_cpu_en", 64'(bus.cpu_en), 64'd1);
    tick();
    tick();
    chk("step_halt_again", 64'(bus.state), 64'd3);
    chk("step_one_cycle", 64'(bus.cycle_count), 64'd6);
    chk("step_bp_sticky", 64'(bus.bp_hit), 64'd1);
    bus.run = 0; bus.bp_en = 0;
    tick();
    chk("halt_to_idle", 64'(bus.state), 64'd0);
    chk("bp_hit_cleared", 64'(bus.bp_hit), 64'd0);

    // Overflow after 20 entries, then pop+write while full
    do_reset();
    bus.run = 1;
    repeat (21) tick();
    chk("ovf_tr_count", 64'(bus.tr_count), 64'd16);
    chk("ovf_flag", 64'(bus.tr_overflow), 64'd1);
    bus.rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_rw_valid", 64'(bus.rd_valid), 64'd1);
      chk("full_rw_pc", bus.rd_pc, 64'h10 + 64'(4 * i));
      chk("full_rw_count", 64'(bus.tr_count), 64'd16);
    end
    bus.rd_en = 0; bus.run = 0;
    tick();

    // Empty pop, then reset in the middle of a run
    do_reset();
    bus.rd_en = 1;
    tick();
    bus.rd_en = 0;
    chk("empty_pop_invalid", 64'(bus.rd_valid), 64'd0);
    bus.run = 1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("midrun_rst_state", 64'(bus.state), 64'd0);
    chk("midrun_rst_cpu_en", 64'(bus.cpu_en), 64'd0);
    chk("midrun_rst_tr_count", 64'(bus.tr_count), 64'd0);
    chk("midrun_rst_cycles", 64'(bus.cycle_count), 64'd0);
    rst_n = 1'b1; bus.run = 0; bus.pc = '0;
    tick();

    // Randomized traffic against the model
    pc_mask = 64'hFF;
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
      bus.step  = ($urandom_range(0, 9) == 0);
      bus.bp_en = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) bus.bp_addr = 64'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) bus.pc = 64'(4 * $urandom_range(0, 63));
      bus.rd_en = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
